ysyx_23060061_axil_sram: RTL and testbench

AXI4-Lite responder modelling the instruction/data SRAM that the fetch unit and LSU drive as initiators. Independent read and write channels, each with its own small FSM and a programmable response latency. Sits at the far end of the IFU/LSU AXI-Lite buses, replacing direct DPI memory access in simulation.

---
 rtl/ysyx_23060061_axil_sram.sv | 216 +++++++++++++++++++++
 tb/tb_ysyx_23060061_axil_sram.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060061_axil_sram.sv
// AXI4-Lite SRAM responder with independent read/write FSMs and latency.
// YSYX_23060061_SRAM_RAND_LAT_EN adds LFSR jitter to both latencies.
module ysyx_23060061_axil_sram #(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int          RD_LAT    = 1,
  parameter int          WR_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [31:0] SPAN   = 32'(4 * DEPTH);
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } w_state_t;

  logic [31:0] mem [DEPTH];

  logic [4:0] rd_load;
  logic [4:0] wr_load;

`ifdef YSYX_23060061_SRAM_RAND_LAT_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0],
               lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign rd_load = 5'(RD_LAT) + {2'b00, lfsr[2:0]};
  assign wr_load = 5'(WR_LAT) + {2'b00, lfsr[2:0]};
`else
  assign rd_load = 5'(RD_LAT);
  assign wr_load = 5'(WR_LAT);
`endif

  r_state_t    rstate;
  logic [4:0]  rcnt;
  logic [31:0] raddr;
  logic [31:0] r_off;
  logic        r_hit;
  logic [AW-1:0] r_idx;

  assign r_off = raddr - ADDR_BASE;
  assign r_hit = (raddr >= ADDR_BASE) && (r_off < SPAN);
  assign r_idx = r_off[AW+1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate  <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= OKAY;
      rcnt    <= '0;
      raddr   <= '0;
    end else begin
      unique case (rstate)
        R_IDLE: begin
          if (arvalid && arready) begin
            raddr   <= araddr;
            rcnt    <= rd_load;
            arready <= 1'b0;
            rstate  <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rcnt == '0) begin
            rvalid <= 1'b1;
            rstate <= R_RESP;
            if (r_hit) begin
              rdata <= mem[r_idx];
              rresp <= OKAY;
            end else begin
              rdata <= '0;
              rresp <= SLVERR;
            end
          end else begin
            rcnt <= rcnt - 5'd1;
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
            rstate  <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  w_state_t    wstate;
  logic [4:0]  wcnt;
  logic [31:0] waddr;
  logic [31:0] wdat;
  logic [3:0]  wstb;
  logic        aw_got;
  logic        w_got;
  logic        have_aw;
  logic        have_w;
  logic [31:0] w_off;
  logic        w_hit;
  logic [AW-1:0] w_idx;
  logic        w_commit;

  assign have_aw  = aw_got | (awvalid & awready);
  assign have_w   = w_got | (wvalid & wready);
  assign w_off    = waddr - ADDR_BASE;
  assign w_hit    = (waddr >= ADDR_BASE) && (w_off < SPAN);
  assign w_idx    = w_off[AW+1:2];
  assign w_commit = (wstate == W_WAIT) && (wcnt == '0) && w_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wstate  <= W_IDLE;
      awready <= 1'b1;
      wready  <= 1'b1;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
      wcnt    <= '0;
      waddr   <= '0;
      wdat    <= '0;
      wstb    <= '0;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
    end else begin
      unique case (wstate)
        W_IDLE: begin
          if (awvalid && awready) begin
            waddr   <= awaddr;
            aw_got  <= 1'b1;
            awready <= 1'b0;
          end
          if (wvalid && wready) begin
            wdat   <= wdata;
            wstb   <= wstrb;
            w_got  <= 1'b1;
            wready <= 1'b0;
          end
          if (have_aw && have_w) begin
            wcnt   <= wr_load;
            wstate <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (wcnt == '0) begin
            bvalid <= 1'b1;
            bresp  <= w_hit ? OKAY : SLVERR;
            wstate <= W_RESP;
          end else begin
            wcnt <= wcnt - 5'd1;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
            wstate  <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Contents survive reset; only a committed write touches the array.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (wstb[i]) begin
          mem[w_idx][8*i +: 8] <= wdat[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060061_axil_sram.sv
// Scoreboard bench for the AXI4-Lite SRAM responder.
// Stimulus queues expected R/B beats; a monitor checks them.
module tb_ysyx_23060061_axil_sram;

  localparam int          DEP  = 4096;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          RDL  = 2;
  localparam int          WRL  = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;

  int total = 0;
  int bad = 0;

  logic [33:0] rq[$];
  logic [1:0]  bq[$];

  always #5 clk = ~clk;

  ysyx_23060061_axil_sram #(
    .DEPTH(DEP),
    .ADDR_BASE(BASE),
    .RD_LAT(RDL),
    .WR_LAT(WRL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .araddr(araddr),
    .arvalid(arvalid),
    .arready(arready),
    .rdata(rdata),
    .rresp(rresp),
    .rvalid(rvalid),
    .rready(rready),
    .awaddr(awaddr),
    .awvalid(awvalid),
    .awready(awready),
    .wdata(wdata),
    .wstrb(wstrb),
    .wvalid(wvalid),
    .wready(wready),
    .bresp(bresp),
    .bvalid(bvalid),
    .bready(bready)
  );

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  // Monitor: one beat per sampled handshake, inputs only change after posedge.
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (rst && rvalid && rready) begin
        if (rq.size() == 0) begin
          chk("r_unexpected", 32'(rvalid), 32'd0);
        end else begin
          e = rq.pop_front();
          chk("r_data", rdata, e[31:0]);
          chk("r_resp", 32'(rresp), 32'(e[33:32]));
        end
      end
      if (rst && bvalid && bready) begin
        if (bq.size() == 0) begin
          chk("b_unexpected", 32'(bvalid), 32'd0);
        end else begin
          chk("b_resp", 32'(bresp), 32'(bq.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic ar_hs(input logic [31:0] a);
    int n;
    araddr  = a;
    arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("ar_ready", 32'(arready), 32'd1);
    sync();
    arvalid = 1'b0;
  endtask

  task automatic wait_rv(output int cyc);
    cyc = 0;
    while (!rvalid && cyc < 50) begin
      sync();
      cyc++;
    end
  endtask

  task automatic wait_bv(output int cyc);
    cyc = 0;
    while (!bvalid && cyc < 50) begin
      sync();
      cyc++;
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ed,
                    input logic [1:0] er);
    int cyc;
    rq.push_back({er, ed});
    ar_hs(a);
    wait_rv(cyc);
    chk("r_lat", 32'(cyc), 32'(RDL + 1));
    sync();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [1:0] er,
                    input bit full);
    int n;
    int cyc;
    if (full) bq.push_back(er);
    awaddr  = a;
    wdata   = d;
    wstrb   = s;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(awready && wready) && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("aw_w_ready", 32'(awready && wready), 32'd1);
    sync();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (full) begin
      wait_bv(cyc);
      chk("b_lat", 32'(cyc), 32'(WRL + 1));
      sync();
    end
  endtask

  initial begin
    int pulses;
    logic prev;
    int cyc;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    sync();
    rst = 1'b1;
    @(negedge clk);
    chk("rel_ready", {29'd0, arready, awready, wready}, 32'd7);
    sync();

    wr(BASE + 32'h10, 32'hDEAD_BEEF, 4'b1111, 2'b00, 1'b1);
    rd(BASE + 32'h10, 32'hDEAD_BEEF, 2'b00);

    wr(BASE + 32'h10, 32'h0000_AB00, 4'b0010, 2'b00, 1'b1);
    rd(BASE + 32'h10, 32'hDEAD_ABEF, 2'b00);

    wr(BASE + 32'h14, 32'h1111_2222, 4'b1111, 2'b00, 1'b1);
    wr(BASE + 32'h14, 32'hFFFF_FFFF, 4'b0000, 2'b00, 1'b1);
    rd(BASE + 32'h14, 32'h1111_2222, 2'b00);

    bq.push_back(2'b00);
    awaddr = BASE + 32'h20;
    wdata  = 32'h1234_5678;
    wstrb  = 4'b1111;
    wvalid = 1'b1;
    @(negedge clk);
    chk("wf_wready", 32'(wready), 32'd1);
    sync();
    wvalid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("wf_wready_lo", 32'(wready), 32'd0);
      chk("wf_awready_hi", 32'(awready), 32'd1);
      chk("wf_no_b", 32'(bvalid), 32'd0);
    end
    sync();
    awvalid = 1'b1;
    @(negedge clk);
    chk("wf_awready", 32'(awready), 32'd1);
    sync();
    awvalid = 1'b0;
    pulses = 0;
    prev = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bvalid && !prev) pulses++;
      prev = bvalid;
    end
    chk("wf_pulses", 32'(pulses), 32'd1);
    sync();
    rd(BASE + 32'h20, 32'h1234_5678, 2'b00);

    rready = 1'b0;
    rq.push_back({2'b00, 32'hDEAD_ABEF});
    ar_hs(BASE + 32'h10);
    wait_rv(cyc);
    chk("hold_lat", 32'(cyc), 32'(RDL + 1));
    repeat (5) begin
      @(negedge clk);
      chk("hold_rvalid", 32'(rvalid), 32'd1);
      chk("hold_rdata", rdata, 32'hDEAD_ABEF);
      chk("hold_rresp", 32'(rresp), 32'd0);
      chk("hold_arready", 32'(arready), 32'd0);
    end
    sync();
    rready = 1'b1;
    sync();
    chk("hold_rvalid_lo", 32'(rvalid), 32'd0);
    chk("hold_arready_hi", 32'(arready), 32'd1);

    wr(BASE, 32'hCAFE_F00D, 4'b1111, 2'b00, 1'b1);
    wr(BASE + 32'(4 * DEP - 4), 32'hA5A5_5A5A, 4'b1111, 2'b00, 1'b1);
    rd(BASE + 32'(4 * DEP - 4), 32'hA5A5_5A5A, 2'b00);
    rd(32'h7FFF_FFFC, 32'h0, 2'b10);
    wr(BASE + 32'(4 * DEP), 32'hFFFF_FFFF, 4'b1111, 2'b10, 1'b1);
    rd(BASE, 32'hCAFE_F00D, 2'b00);
    rd(BASE + 32'(4 * DEP), 32'h0, 2'b10);

    wr(BASE + 32'h10, 32'h5555_5555, 4'b1111, 2'b00, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    sync();
    chk("post_rst_ready", {29'd0, arready, awready, wready}, 32'd7);
    repeat (4) @(negedge clk);
    chk("post_rst_no_b", 32'(bvalid), 32'd0);
    sync();
    rd(BASE + 32'h10, 32'hDEAD_ABEF, 2'b00);

    repeat (3) sync();
    chk("rq_empty", 32'(rq.size()), 32'd0);
    chk("bq_empty", 32'(bq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
